wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that owns the register file's single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). Every cycle it merges two result sources: the in-order ALU/memory writeback path, which cannot be back-pressured, and the multi-cycle multdiv unit, which uses a valid/ready handshake. Multdiv results that collide with ALU writes wait in a 2-entry FIFO. The block also raises read-hazard flags for the decode stage while a write to a register is still pending.

## Interface
- `RSTATUS_REG`, default 30: register that receives overflow status codes.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `ctrl_reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU-path result present this cycle; never stalled.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ovf_code`  in  3  non-zero means overflow (1 add, 2 addi, 3 sub).
- `md_valid`  in  1  multdiv result offered.
- `md_ready`  out  1  arbiter can accept the multdiv result.
- `md_rd`  in  5  multdiv destination register.
- `md_data`  in  32  multdiv result.
- `md_ovf_code`  in  3  non-zero means exception (4 mul, 5 div).
- `ctrl_readRegA`, `ctrl_readRegB`  in  5 each  decode-stage read addresses, checked for hazards.
- `hazard_a`, `hazard_b`  out  1 each  combinational; the matching read address has a pending write.
- `ctrl_writeEnable`  out  1  registered register-file write enable.
- `ctrl_writeReg`  out  5  registered write address.
- `data_writeReg`  out  32  registered write data.

## Operation
- Result normalisation: if the overflow code is non-zero (and the macro is enabled), rd becomes `RSTATUS_REG` and data becomes `{29'b0, code}`. The original rd is not written.
- Results whose normalised rd is 0 are discarded. They do not use the port and are not enqueued. A multdiv result to r0 still completes its handshake.
- Multdiv acceptance: `md_fire = md_valid & md_ready`, with `md_ready = (count < 2)`.
- Port selection, in priority order each cycle:
  - ALU result, if `alu_valid` and rd is not 0.
  - Otherwise the FIFO head, if count > 0.
  - Otherwise a fired multdiv result, passed straight through to the output register. This is only legal when the FIFO is empty, so ordering is preserved.
- Enqueue: a fired multdiv result that did not win the port is pushed to the FIFO tail. At most one push per cycle.
- Pop and push in the same cycle are allowed at count 1; count is unchanged.
- The FIFO drains strictly in order. Continuous ALU traffic may starve it indefinitely; `md_ready` stays low at count 2.
- Hazard flag: `hazard_x = 1` when `ctrl_readRegX` is non-zero and equals either of the following:
  - the rd of any valid FIFO entry, or
  - `ctrl_writeReg` while `ctrl_writeEnable = 1`. This second check can be dropped only if the register file bypasses writes; it does not, so the check stays.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream): `ctrl_writeEnable=0`, `ctrl_writeReg=0`, `data_writeReg=0`, count=0, FIFO entries invalid, `md_ready=1`, `hazard_a=hazard_b=0`.
- Latency: a result accepted in cycle N is on the write port in cycle N+1 and lands in the register file at the end of N+1.
- A result that waits in the FIFO adds one cycle per blocking ALU write.
- `ctrl_writeEnable` is high for exactly one cycle per write and is low on idle cycles. Address and data hold their last value when idle.
- Reset asserted mid-operation flushes queued results; they are lost.
- `md_ready` depends only on registered count. It never depends combinationally on `md_valid`.

## Configuration
- `WB_RSTATUS_EN` defined: overflow codes redirect the write to `RSTATUS_REG` as described above.
- Not defined: `alu_ovf_code` and `md_ovf_code` are ignored, and results always go to their own rd.

## Structure
- Shared package holds:
  - the `wb_entry_t` struct `{rd[4:0], data[31:0]}`,
  - `RSTATUS_REG_DEFAULT = 30`,
  - the overflow code constants `OVF_ADD=1`, `OVF_ADDI=2`, `OVF_SUB=3`, `OVF_MUL=4`, `OVF_DIV=5`.
- One sub-module, `wb_fifo2`: a 2-entry in-order queue with push, pop, count and per-entry rd visibility for the hazard compare.
- Normalisation and arbitration stay in the top level.

## Test plan
- **Reset values:** hold `ctrl_reset_n=0` for 3 cycles -> all outputs 0 and `md_ready=1`; release -> port idle.
- **Collision:** `alu_valid` with rd=5, data=0x11, and `md_valid` with rd=7, data=0x22 in cycle N -> cycle N+1 writes r5=0x11; cycle N+2 writes r7=0x22; `hazard` for r7 is high in N+1 and N+2.
- **Backpressure:** ALU writes every cycle with 3 multdiv results offered -> `md_ready` falls after 2 are accepted; the third is accepted one cycle after ALU traffic stops; all 3 written in order.
- **Overflow redirect:** `alu_ovf_code=3` with rd=9 -> writes r30=0x3 and r9 is untouched. Without `WB_RSTATUS_EN` -> writes r9 with `alu_data`.
- **r0 filtering:** ALU write to r0 in the same cycle as a multdiv write to r4 -> `ctrl_writeEnable` never shows reg 0, and r4 is written at N+1 via the passthrough.
- **Reset mid-operation:** assert reset with 2 FIFO entries queued -> count=0 and no further writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// The WB_RSTATUS_EN overflow redirect uses wb_redirect() from here.
package wb_arbiter_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   localparam int unsigned RSTATUS_REG_DEFAULT = 30;

   localparam logic [2:0] OVF_ADD  = 3'd1;
   localparam logic [2:0] OVF_ADDI = 3'd2;
   localparam logic [2:0] OVF_SUB  = 3'd3;
   localparam logic [2:0] OVF_MUL  = 3'd4;
   localparam logic [2:0] OVF_DIV  = 3'd5;

   // A non-zero code replaces the result with the code itself, aimed at the status register.
   function automatic wb_entry_t wb_redirect(input wb_entry_t e, input logic [2:0] code,
                                             input logic [4:0] rstatus);
      wb_entry_t r;
      r = e;
      if (code != 3'd0) begin
         r.rd   = rstatus;
         r.data = {29'd0, code};
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result producers / decode stage and the writeback arbiter.
// Handshake: a multdiv result transfers on a rising edge where md_valid & md_ready; md_ready is registered-only.
interface wb_arbiter_if;

   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic [2:0]  alu_ovf_code;

   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic [2:0]  md_ovf_code;

   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic        hazard_a;
   logic        hazard_b;

   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   logic [1:0]  dbg_count;

   modport slave (
      input  alu_valid, alu_rd, alu_data, alu_ovf_code,
      input  md_valid, md_rd, md_data, md_ovf_code,
      input  ctrl_readRegA, ctrl_readRegB,
      output md_ready, hazard_a, hazard_b,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output dbg_count
   );

   modport master (
      output alu_valid, alu_rd, alu_data, alu_ovf_code,
      output md_valid, md_rd, md_data, md_ovf_code,
      output ctrl_readRegA, ctrl_readRegB,
      input  md_ready, hazard_a, hazard_b,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  dbg_count
   );

endinterface

// File: rtl/wb_arbiter_fifo2.sv
// Two-entry in-order queue for multdiv results that lost the write port.
// Entry 0 is always the head; both entry rds are exposed for hazard checks.
module wb_fifo2
   import wb_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  wb_entry_t  push_entry,
   output wb_entry_t  head,
   output logic [1:0] count,
   output logic [4:0] rd0,
   output logic [4:0] rd1,
   output logic       vld0,
   output logic       vld1
);

   wb_entry_t e0;
   wb_entry_t e1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         e0    <= '0;
         e1    <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= push_entry;
               else               e1 <= push_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop/push keeps the count; the new entry lands behind any survivor.
               if (count == 2'd1) begin
                  e0 <= push_entry;
               end else begin
                  e0 <= e1;
                  e1 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = e0;
   assign rd0  = e0.rd;
   assign rd1  = e1.rd;
   assign vld0 = (count != 2'd0);
   assign vld1 = (count == 2'd2);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU path and the multdiv handshake onto one register-file write port.
// Define WB_RSTATUS_EN to redirect overflow results to RSTATUS_REG.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned RSTATUS_REG = RSTATUS_REG_DEFAULT
)
(
   input  logic         clock,
   input  logic         ctrl_reset_n,
   wb_arbiter_if.slave  bus
);

   localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

   wb_entry_t  alu_raw;
   wb_entry_t  md_raw;
   wb_entry_t  alu_e;
   wb_entry_t  md_e;
   wb_entry_t  head;
   wb_entry_t  win;
   logic       win_valid;
   logic [1:0] count;
   logic [4:0] rd0;
   logic [4:0] rd1;
   logic       vld0;
   logic       vld1;
   logic       md_ready;
   logic       md_fire;
   logic       alu_live;
   logic       md_live;
   logic       push;
   logic       pop;
   logic       we;
   logic [4:0] wreg;
   logic [31:0] wdata;

   assign alu_raw = {bus.alu_rd, bus.alu_data};
   assign md_raw  = {bus.md_rd, bus.md_data};

`ifdef WB_RSTATUS_EN
   assign alu_e = wb_redirect(alu_raw, bus.alu_ovf_code, RSTATUS_RD);
   assign md_e  = wb_redirect(md_raw, bus.md_ovf_code, RSTATUS_RD);
`else
   logic unused_ovf;
   assign unused_ovf = ^{bus.alu_ovf_code, bus.md_ovf_code, RSTATUS_RD};
   assign alu_e = alu_raw;
   assign md_e  = md_raw;
`endif

   assign md_ready = (count < 2'd2);
   assign md_fire  = bus.md_valid & md_ready;
   assign alu_live = bus.alu_valid & (alu_e.rd != 5'd0);
   // An r0 multdiv result still completes its handshake; it just never reaches the port or queue.
   assign md_live  = md_fire & (md_e.rd != 5'd0);

   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      pop       = 1'b0;
      push      = 1'b0;
      if (alu_live) begin
         win_valid = 1'b1;
         win       = alu_e;
         push      = md_live;
      end else if (count != 2'd0) begin
         win_valid = 1'b1;
         win       = head;
         pop       = 1'b1;
         push      = md_live;
      end else if (md_live) begin
         win_valid = 1'b1;
         win       = md_e;
      end
   end

   wb_fifo2 u_fifo (
      .clock      (clock),
      .rst_n      (ctrl_reset_n),
      .push       (push),
      .pop        (pop),
      .push_entry (md_e),
      .head       (head),
      .count      (count),
      .rd0        (rd0),
      .rd1        (rd1),
      .vld0       (vld0),
      .vld1       (vld1)
   );

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         we    <= 1'b0;
         wreg  <= 5'd0;
         wdata <= 32'd0;
      end else begin
         we <= win_valid;
         if (win_valid) begin
            wreg  <= win.rd;
            wdata <= win.data;
         end
      end
   end

   // The register file does not bypass, so the write in flight on the port still counts as pending.
   assign bus.hazard_a = (bus.ctrl_readRegA != 5'd0) &&
                         ((vld0 && rd0 == bus.ctrl_readRegA) ||
                          (vld1 && rd1 == bus.ctrl_readRegA) ||
                          (we && wreg == bus.ctrl_readRegA));
   assign bus.hazard_b = (bus.ctrl_readRegB != 5'd0) &&
                         ((vld0 && rd0 == bus.ctrl_readRegB) ||
                          (vld1 && rd1 == bus.ctrl_readRegB) ||
                          (we && wreg == bus.ctrl_readRegB));

   assign bus.md_ready         = md_ready;
   assign bus.ctrl_writeEnable = we;
   assign bus.ctrl_writeReg    = wreg;
   assign bus.data_writeReg    = wdata;
   assign bus.dbg_count        = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
// Works with or without WB_RSTATUS_EN defined.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic clock = 1'b0;
   logic ctrl_reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   wb_arbiter_if bus ();

   wb_arbiter #(.RSTATUS_REG(30)) dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .bus          (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of waiting multdiv results and the expected port registers.
   logic [36:0] exp_q[$];
   logic        m_we = 1'b0;
   logic [4:0]  m_wreg = 5'd0;
   logic [31:0] m_wdata = 32'd0;

   function automatic logic [36:0] norm(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] c);
      logic [36:0] r;
      r = {rd, d};
`ifdef WB_RSTATUS_EN
      if (c != 3'd0) r = {5'd30, 29'd0, c};
`else
      if (c == 3'd7) r = {rd, d};
`endif
      return r;
   endfunction

   function automatic logic m_hazard(input logic [4:0] r);
      logic h;
      h = 1'b0;
      if (r != 5'd0) begin
         foreach (exp_q[i]) if (exp_q[i][36:32] == r) h = 1'b1;
         if (m_we && m_wreg == r) h = 1'b1;
      end
      return h;
   endfunction

   always @(posedge clock or negedge ctrl_reset_n) begin : model
      logic [36:0] a;
      logic [36:0] m;
      logic        alu_ok;
      logic        md_ok;
      if (!ctrl_reset_n) begin
         exp_q.delete();
         m_we    = 1'b0;
         m_wreg  = 5'd0;
         m_wdata = 32'd0;
      end else begin
         a      = norm(bus.alu_rd, bus.alu_data, bus.alu_ovf_code);
         m      = norm(bus.md_rd, bus.md_data, bus.md_ovf_code);
         alu_ok = bus.alu_valid && a[36:32] != 5'd0;
         md_ok  = bus.md_valid && (exp_q.size() < 2) && m[36:32] != 5'd0;
         m_we   = 1'b1;
         if (alu_ok) begin
            {m_wreg, m_wdata} = a;
            if (md_ok) exp_q.push_back(m);
         end else if (exp_q.size() > 0) begin
            {m_wreg, m_wdata} = exp_q.pop_front();
            if (md_ok) exp_q.push_back(m);
         end else if (md_ok) begin
            {m_wreg, m_wdata} = m;
         end else begin
            m_we = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      check("we", bus.ctrl_writeEnable, m_we);
      check("wreg", bus.ctrl_writeReg, m_wreg);
      check("wdata", bus.data_writeReg, m_wdata);
      check("md_ready", bus.md_ready, exp_q.size() < 2);
      check("count", bus.dbg_count, exp_q.size());
      check("hazard_a", bus.hazard_a, m_hazard(bus.ctrl_readRegA));
      check("hazard_b", bus.hazard_b, m_hazard(bus.ctrl_readRegB));
   end

   task automatic idle_inputs();
      bus.alu_valid    = 1'b0;
      bus.alu_rd       = 5'd0;
      bus.alu_data     = 32'd0;
      bus.alu_ovf_code = 3'd0;
      bus.md_valid     = 1'b0;
      bus.md_rd        = 5'd0;
      bus.md_data      = 32'd0;
      bus.md_ovf_code  = 3'd0;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] c);
      bus.alu_valid    = 1'b1;
      bus.alu_rd       = rd;
      bus.alu_data     = d;
      bus.alu_ovf_code = c;
   endtask

   task automatic set_md(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] c);
      bus.md_valid    = 1'b1;
      bus.md_rd       = rd;
      bus.md_data     = d;
      bus.md_ovf_code = c;
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic expect_wr(input string name, input logic we, input logic [4:0] r, input logic [31:0] d);
      check({name, "_we"}, bus.ctrl_writeEnable, we);
      if (we) begin
         check({name, "_reg"}, bus.ctrl_writeReg, r);
         check({name, "_data"}, bus.data_writeReg, d);
      end
   endtask

   logic [36:0] wr_seen[$];
   logic [36:0] bp_exp[7];
   logic [36:0] md_items[3];
   int          fire_cyc[3];

   initial begin
      int mi;
      logic rdy;
      logic vld;
      idle_inputs();
      bus.ctrl_readRegA = 5'd3;
      bus.ctrl_readRegB = 5'd0;

      // Reset values
      repeat (3) tick();
      expect_wr("rst", 1'b0, 5'd0, 32'd0);
      check("rst_wreg", bus.ctrl_writeReg, 5'd0);
      check("rst_wdata", bus.data_writeReg, 32'd0);
      check("rst_ready", bus.md_ready, 1'b1);
      check("rst_haz_a", bus.hazard_a, 1'b0);
      check("rst_count", bus.dbg_count, 2'd0);
      ctrl_reset_n = 1'b1;
      tick();
      expect_wr("rel_idle", 1'b0, 5'd0, 32'd0);

      // Collision: ALU wins, multdiv waits one cycle
      set_alu(5'd5, 32'h11, 3'd0);
      set_md(5'd7, 32'h22, 3'd0);
      bus.ctrl_readRegA = 5'd7;
      bus.ctrl_readRegB = 5'd5;
      tick();
      idle_inputs();
      expect_wr("coll_n1", 1'b1, 5'd5, 32'h11);
      check("coll_haz7_n1", bus.hazard_a, 1'b1);
      check("coll_haz5_n1", bus.hazard_b, 1'b1);
      check("coll_count_n1", bus.dbg_count, 2'd1);
      tick();
      expect_wr("coll_n2", 1'b1, 5'd7, 32'h22);
      check("coll_haz7_n2", bus.hazard_a, 1'b1);
      check("coll_haz5_n2", bus.hazard_b, 1'b0);
      tick();
      expect_wr("coll_n3", 1'b0, 5'd0, 32'd0);
      check("coll_haz7_n3", bus.hazard_a, 1'b0);

      // Backpressure: four ALU cycles, three multdiv results
      md_items[0] = {5'd10, 32'hA0};
      md_items[1] = {5'd11, 32'hB0};
      md_items[2] = {5'd12, 32'hC0};
      bp_exp[0] = {5'd1, 32'h100};
      bp_exp[1] = {5'd2, 32'h101};
      bp_exp[2] = {5'd3, 32'h102};
      bp_exp[3] = {5'd4, 32'h103};
      bp_exp[4] = {5'd10, 32'hA0};
      bp_exp[5] = {5'd11, 32'hB0};
      bp_exp[6] = {5'd12, 32'hC0};
      bus.ctrl_readRegA = 5'd11;
      bus.ctrl_readRegB = 5'd12;
      mi = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < 4) set_alu(5'(c + 1), 32'h100 + 32'(c), 3'd0);
         else       bus.alu_valid = 1'b0;
         if (mi < 3) set_md(md_items[mi][36:32], md_items[mi][31:0], 3'd0);
         else        bus.md_valid = 1'b0;
         rdy = bus.md_ready;
         vld = bus.md_valid;
         tick();
         if (vld && rdy) begin
            fire_cyc[mi] = c;
            mi++;
         end
         if (bus.ctrl_writeEnable) wr_seen.push_back({bus.ctrl_writeReg, bus.data_writeReg});
      end
      idle_inputs();
      check("bp_accepted", 37'(mi), 37'd3);
      check("bp_fire0", 37'(fire_cyc[0]), 37'd0);
      check("bp_fire1", 37'(fire_cyc[1]), 37'd1);
      check("bp_fire2", 37'(fire_cyc[2]), 37'd5);
      check("bp_nwrites", 37'(wr_seen.size()), 37'd7);
      for (int i = 0; i < 7 && i < wr_seen.size(); i++) check($sformatf("bp_wr%0d", i), wr_seen[i], bp_exp[i]);

      // Overflow redirect
      bus.ctrl_readRegA = 5'd9;
      bus.ctrl_readRegB = 5'd30;
      set_alu(5'd9, 32'hDEAD, OVF_SUB);
      tick();
      idle_inputs();
`ifdef WB_RSTATUS_EN
      expect_wr("ovf_alu", 1'b1, 5'd30, 32'h3);
`else
      expect_wr("ovf_alu", 1'b1, 5'd9, 32'hDEAD);
`endif
      set_md(5'd6, 32'h77, OVF_MUL);
      tick();
      idle_inputs();
`ifdef WB_RSTATUS_EN
      expect_wr("ovf_md", 1'b1, 5'd30, 32'h4);
`else
      expect_wr("ovf_md", 1'b1, 5'd6, 32'h77);
`endif
      set_alu(5'd0, 32'h5, OVF_ADD);
      tick();
      idle_inputs();
`ifdef WB_RSTATUS_EN
      expect_wr("ovf_r0", 1'b1, 5'd30, 32'h1);
`else
      expect_wr("ovf_r0", 1'b0, 5'd0, 32'd0);
`endif
      tick();
      expect_wr("ovf_idle", 1'b0, 5'd0, 32'd0);

      // r0 filtering
      bus.ctrl_readRegA = 5'd4;
      bus.ctrl_readRegB = 5'd0;
      set_alu(5'd0, 32'h55, 3'd0);
      set_md(5'd4, 32'h44, 3'd0);
      tick();
      idle_inputs();
      expect_wr("r0_pass", 1'b1, 5'd4, 32'h44);
      check("r0_pass_count", bus.dbg_count, 2'd0);
      check("r0_haz_b", bus.hazard_b, 1'b0);
      set_md(5'd0, 32'h99, 3'd0);
      check("r0_md_ready", bus.md_ready, 1'b1);
      tick();
      idle_inputs();
      expect_wr("r0_md", 1'b0, 5'd0, 32'd0);
      check("r0_md_count", bus.dbg_count, 2'd0);

      // Reset with two results queued
      bus.ctrl_readRegA = 5'd20;
      bus.ctrl_readRegB = 5'd21;
      set_alu(5'd1, 32'h1, 3'd0);
      set_md(5'd20, 32'h200, 3'd0);
      tick();
      set_alu(5'd2, 32'h2, 3'd0);
      set_md(5'd21, 32'h210, 3'd0);
      tick();
      idle_inputs();
      check("mid_count2", bus.dbg_count, 2'd2);
      check("mid_ready0", bus.md_ready, 1'b0);
      check("mid_haz20", bus.hazard_a, 1'b1);
      ctrl_reset_n = 1'b0;
      #1;
      check("mid_rst_we", bus.ctrl_writeEnable, 1'b0);
      check("mid_rst_count", bus.dbg_count, 2'd0);
      check("mid_rst_ready", bus.md_ready, 1'b1);
      check("mid_rst_haz", bus.hazard_a, 1'b0);
      tick();
      tick();
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_wr($sformatf("post_rst%0d", i), 1'b0, 5'd0, 32'd0);
         check($sformatf("post_rst_haz%0d", i), bus.hazard_b, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
